// File: rtl/ps2_pkg.sv
// ps2_pkg
// Shared definitions for the PS/2 keyboard receiver:
//   - PS2_EXT / PS2_BRK : extended and break prefix scancodes
//   - pfx_state_t       : prefix FSM encoding (bit 0 = ext seen, bit 1 = brk seen)
//   - EV_W, ps2_event_t : queued key event {ext, brk, code[7:0]}
//   - odd_parity_ok     : frame parity helper over data+parity bits
package ps2_pkg;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    localparam int EV_W = 10;

    typedef enum logic [1:0] {
        PFX_IDLE    = 2'd0,
        PFX_EXT     = 2'd1,
        PFX_BRK     = 2'd2,
        PFX_EXT_BRK = 2'd3
    } pfx_state_t;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_event_t;

    // PS/2 uses odd parity: the eight data bits plus the parity bit
    // must contain an odd number of ones.
    function automatic logic odd_parity_ok(input logic [8:0] bits);
        return ^bits;
    endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// ps2_event_fifo
// Show-ahead synchronous FIFO for decoded key events.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   push         : write request for push_data
//   push_data    : event to enqueue
//   pop          : consumer accepted the head entry (ignored while empty)
//   head         : current head entry (valid while empty == 0)
//   empty        : no entries stored
//   ovf          : one-cycle pulse when a push is dropped because the FIFO is full
//
// Handshake: the head entry is offered whenever empty == 0; it is consumed on
// any clock edge where the consumer holds pop high while an entry is present.
// A push into a full FIFO succeeds only if a pop frees a slot on the same edge.
module ps2_event_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             ovf
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    // One extra pointer bit distinguishes full from empty when the indices match.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             full;
    logic             do_pop;
    logic             do_push;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ovf    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            ovf <= push && full && !do_pop;
        end
    end

endmodule

// File: rtl/ps2_kbd_rx.sv
// ps2_kbd_rx
// PS/2 keyboard receiver: filters ps2clk, assembles 11-bit frames, decodes the
// E0 (extended) / F0 (break) prefixes into key events, queues events in a
// small FIFO and keeps a history of released keys.
// Ports:
//   clk, reset           : system clock, asynchronous active-high reset
//   ps2clk, ps2data      : raw PS/2 pins (asynchronous)
//   ev_valid / ev_ready  : event handshake; head is consumed on an edge where both are high
//   ev_code, ev_ext, ev_brk : head event fields
//   hist                 : released-key history, [7:0] newest
//   frame_err            : one-cycle pulse on a bad frame or partial-frame timeout
//   ovf                  : one-cycle pulse when an event is dropped (FIFO full)
module ps2_kbd_rx
    import ps2_pkg::*;
#(
    parameter int FILT_LEN    = 8,
    parameter int HIST_DEPTH  = 3,
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 50000,
    parameter int REPORT_MAKE = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ps2clk,
    input  logic                    ps2data,
    output logic                    ev_valid,
    input  logic                    ev_ready,
    output logic [7:0]              ev_code,
    output logic                    ev_ext,
    output logic                    ev_brk,
    output logic [8*HIST_DEPTH-1:0] hist,
    output logic                    frame_err,
    output logic                    ovf
);

    localparam int HALF   = FILT_LEN / 2;
    localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);

    // ------------------------------------------------------------------
    // ps2clk filter: newest sample enters at bit 0. A fall is a full half
    // window of ones followed by a full half window of zeros, so any low
    // pulse shorter than HALF clks never qualifies.
    // ------------------------------------------------------------------
    logic [FILT_LEN-1:0] samp;
    logic [1:0]          data_sync;
    logic                data_s;
    logic                fall;

    assign fall   = (samp[FILT_LEN-1:HALF] == '1) && (samp[HALF-1:0] == '0);
    assign data_s = data_sync[1];

    // ------------------------------------------------------------------
    // Frame assembly. shift holds {parity, d7..d0, start} once cnt == 10.
    // ------------------------------------------------------------------
    logic [3:0]        cnt;
    logic [9:0]        shift;
    logic [IDLE_W-1:0] idle;
    logic              frame_done;
    logic              frame_ok;
    logic              frame_bad;
    logic              timeout;
    logic [7:0]        data_byte;

    assign data_byte  = shift[8:1];
    assign frame_done = fall && (cnt == 4'd10);
    assign frame_ok   = frame_done && !shift[0] && data_s && odd_parity_ok(shift[9:1]);
    assign frame_bad  = frame_done && !frame_ok;
    // Fires on the TIMEOUT_CYC-th consecutive clk without a fall mid-frame.
    assign timeout    = (cnt != 4'd0) && !fall && (idle == IDLE_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            samp      <= '0;
            data_sync <= '0;
            cnt       <= '0;
            shift     <= '0;
            idle      <= '0;
            frame_err <= 1'b0;
        end else begin
            samp      <= {samp[FILT_LEN-2:0], ps2clk};
            data_sync <= {data_sync[0], ps2data};
            frame_err <= timeout || frame_bad;
            if (timeout) begin
                cnt   <= '0;
                shift <= '0;
                idle  <= '0;
            end else if (fall) begin
                idle <= '0;
                if (cnt == 4'd10) begin
                    cnt <= '0;
                end else begin
                    shift <= {data_s, shift[9:1]};
                    cnt   <= cnt + 4'd1;
                end
            end else if (cnt != 4'd0) begin
                idle <= idle + IDLE_W'(1);
            end else begin
                idle <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Prefix FSM. The state encodes which prefixes have been seen since the
    // last completed key, so repeated E0/F0 simply leave their bit set.
    // ------------------------------------------------------------------
    pfx_state_t pfx;
    logic       ext_now;
    logic       brk_now;
    logic       emit;
    logic       push;
    ps2_event_t push_ev;

    assign ext_now = (pfx == PFX_EXT) || (pfx == PFX_EXT_BRK);
    assign brk_now = (pfx == PFX_BRK) || (pfx == PFX_EXT_BRK);
    assign emit    = frame_ok && (data_byte != PS2_EXT) && (data_byte != PS2_BRK);
    assign push    = emit && (brk_now || (REPORT_MAKE != 0));
    assign push_ev = '{ext: ext_now, brk: brk_now, code: data_byte};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pfx <= PFX_IDLE;
        end else if (timeout || frame_bad) begin
            pfx <= PFX_IDLE;
        end else if (frame_ok) begin
            case (data_byte)
                PS2_EXT: pfx <= brk_now ? PFX_EXT_BRK : PFX_EXT;
                PS2_BRK: pfx <= ext_now ? PFX_EXT_BRK : PFX_BRK;
                default: pfx <= PFX_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Release history: updated on every break event, whether or not the
    // FIFO had room for it.
    // ------------------------------------------------------------------
    logic [8*HIST_DEPTH+7:0] hist_next;

    assign hist_next = {hist, data_byte};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist <= '0;
        end else if (emit && brk_now) begin
            hist <= hist_next[8*HIST_DEPTH-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Event queue
    // ------------------------------------------------------------------
    logic [EV_W-1:0] head_bits;
    ps2_event_t      head_ev;
    logic            fifo_empty;

    ps2_event_fifo #(
        .WIDTH (EV_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_ev),
        .pop       (ev_ready),
        .head      (head_bits),
        .empty     (fifo_empty),
        .ovf       (ovf)
    );

    assign head_ev  = head_bits;
    assign ev_valid = !fifo_empty;
    assign ev_code  = head_ev.code;
    assign ev_ext   = head_ev.ext;
    assign ev_brk   = head_ev.brk;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
module tb_ps2_kbd_rx;

  localparam int FILT_LEN    = 8;
  localparam int HIST_DEPTH  = 3;
  localparam int FIFO_DEPTH  = 4;
  localparam int TIMEOUT_CYC = 200;
  localparam int HALF_BIT    = 8;

  // ---------------- clock / reset / DUTs ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ps2clk = 1'b1;
  logic ps2data = 1'b1;
  logic ready0 = 1'b0;
  logic ready1 = 1'b0;
  logic valid0, valid1, ext0, ext1, brk0, brk1, err0, err1, ovf0, ovf1;
  logic [7:0] code0, code1;
  logic [8*HIST_DEPTH-1:0] hist0, hist1;

  always #5 clk = ~clk;

  // dut0 queues break events only, dut1 also queues make events.
  ps2_kbd_rx #(.FILT_LEN(FILT_LEN), .HIST_DEPTH(HIST_DEPTH), .FIFO_DEPTH(FIFO_DEPTH),
               .TIMEOUT_CYC(TIMEOUT_CYC), .REPORT_MAKE(0)) dut0 (
    .clk(clk), .reset(reset), .ps2clk(ps2clk), .ps2data(ps2data),
    .ev_valid(valid0), .ev_ready(ready0), .ev_code(code0), .ev_ext(ext0), .ev_brk(brk0),
    .hist(hist0), .frame_err(err0), .ovf(ovf0));

  ps2_kbd_rx #(.FILT_LEN(FILT_LEN), .HIST_DEPTH(HIST_DEPTH), .FIFO_DEPTH(FIFO_DEPTH),
               .TIMEOUT_CYC(TIMEOUT_CYC), .REPORT_MAKE(1)) dut1 (
    .clk(clk), .reset(reset), .ps2clk(ps2clk), .ps2data(ps2data),
    .ev_valid(valid1), .ev_ready(ready1), .ev_code(code1), .ev_ext(ext1), .ev_brk(brk1),
    .hist(hist1), .frame_err(err1), .ovf(ovf1));

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int failures = 0;
  int err_seen[2] = '{0, 0};
  int ovf_seen[2] = '{0, 0};
  logic [9:0] exp_q0[$];
  logic [9:0] exp_q1[$];

  // reference model (byte level)
  bit m_ext, m_brk;
  logic [23:0] m_hist;
  int m_err[2];
  int m_ovf[2];
  int err_base[2];
  int ovf_base[2];

  int e_base0, e_base1, o_base0, o_base1;
  int r;
  logic [7:0] rcode;
  bit rbad;

  always @(negedge clk) begin
    if (err0) err_seen[0]++;
    if (err1) err_seen[1]++;
    if (ovf0) ovf_seen[0]++;
    if (ovf1) ovf_seen[1]++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic ps2_bit(input logic b, input bit glitch);
    @(negedge clk);
    ps2data = b;
    ps2clk = 1'b1;
    repeat (2) @(negedge clk);
    if (glitch) begin
      ps2clk = 1'b0;
      repeat (FILT_LEN / 2 - 1) @(negedge clk);
      ps2clk = 1'b1;
    end
    repeat (HALF_BIT) @(negedge clk);
    ps2clk = 1'b0;
    repeat (HALF_BIT) @(negedge clk);
  endtask

  task automatic send_bits(input logic [7:0] code, input bit bad, input int nbits, input int glitch_at);
    logic [10:0] bits;
    bits = {1'b1, (~^code) ^ bad, code, 1'b0};
    for (int i = 0; i < nbits; i++) ps2_bit(bits[i], i == glitch_at);
    @(negedge clk);
    ps2clk = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] code, input bit bad);
    send_bits(code, bad, 11, -1);
  endtask

  task automatic partial_timeout();
    send_bits(8'h2A, 1'b0, 5, -1);
    repeat (TIMEOUT_CYC + 1) @(negedge clk);
  endtask

  task automatic pop_both();
    @(negedge clk);
    ready0 = valid0;
    ready1 = valid1;
    @(negedge clk);
    ready0 = 1'b0;
    ready1 = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (FILT_LEN + 2) @(negedge clk);
  endtask

  // Consume every queued entry of one instance and compare with its expected queue.
  task automatic drain(input int idx);
    logic [9:0] got;
    logic v;
    int extra;
    extra = 0;
    for (int c = 0; c < FIFO_DEPTH + 3; c++) begin
      @(negedge clk);
      v   = (idx == 0) ? valid0 : valid1;
      got = (idx == 0) ? {ext0, brk0, code0} : {ext1, brk1, code1};
      if (v) begin
        if (idx == 0) begin
          if (exp_q0.size() == 0) extra++;
          else check("drain_head0", got, exp_q0.pop_front());
        end else begin
          if (exp_q1.size() == 0) extra++;
          else check("drain_head1", got, exp_q1.pop_front());
        end
      end
      if (idx == 0) ready0 = 1'b1; else ready1 = 1'b1;
    end
    ready0 = 1'b0;
    ready1 = 1'b0;
    @(negedge clk);
    v = (idx == 0) ? valid0 : valid1;
    check("drain_extra", extra, 0);
    check("drain_leftover", (idx == 0) ? exp_q0.size() : exp_q1.size(), 0);
    check("drain_valid_low", v, 0);
  endtask

  // ---------------- reference model ----------------
  task automatic model_reset();
    m_ext = 0;
    m_brk = 0;
    m_hist = '0;
    for (int i = 0; i < 2; i++) begin
      m_err[i] = 0;
      m_ovf[i] = 0;
      err_base[i] = err_seen[i];
      ovf_base[i] = ovf_seen[i];
    end
    exp_q0.delete();
    exp_q1.delete();
  endtask

  task automatic model_push(input int idx, input logic [9:0] ev);
    if (idx == 0) begin
      if (exp_q0.size() < FIFO_DEPTH) exp_q0.push_back(ev); else m_ovf[0]++;
    end else begin
      if (exp_q1.size() < FIFO_DEPTH) exp_q1.push_back(ev); else m_ovf[1]++;
    end
  endtask

  task automatic model_byte(input logic [7:0] code, input bit bad);
    if (bad) begin
      m_err[0]++;
      m_err[1]++;
      m_ext = 0;
      m_brk = 0;
    end else if (code == 8'hE0) begin
      m_ext = 1;
    end else if (code == 8'hF0) begin
      m_brk = 1;
    end else begin
      if (m_brk) begin
        m_hist = (m_hist << 8) | {16'h0, code};
        model_push(0, {m_ext, m_brk, code});
      end
      model_push(1, {m_ext, m_brk, code});
      m_ext = 0;
      m_brk = 0;
    end
  endtask

  task automatic model_timeout();
    m_err[0]++;
    m_err[1]++;
    m_ext = 0;
    m_brk = 0;
  endtask

  task automatic compare_model();
    check("rnd_err0", err_seen[0] - err_base[0], m_err[0]);
    check("rnd_err1", err_seen[1] - err_base[1], m_err[1]);
    check("rnd_ovf0", ovf_seen[0] - ovf_base[0], m_ovf[0]);
    check("rnd_ovf1", ovf_seen[1] - ovf_base[1], m_ovf[1]);
    check("rnd_hist0", hist0, m_hist);
    check("rnd_hist1", hist1, m_hist);
    drain(0);
    drain(1);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [7:0]  code;
    bit          bad;
    int          n_err;
    bit          ev0;
    bit          ev1;
    logic [9:0]  ev;
    logic [23:0] hist;
  } vec_t;

  vec_t tbl[11];

  initial begin
    tbl[0]  = '{8'h1C, 0, 0, 0, 1, 10'h01C, 24'h000000};
    tbl[1]  = '{8'hF0, 0, 0, 0, 0, 10'h000, 24'h000000};
    tbl[2]  = '{8'h1C, 0, 0, 1, 1, 10'h11C, 24'h00001C};
    tbl[3]  = '{8'hE0, 0, 0, 0, 0, 10'h000, 24'h00001C};
    tbl[4]  = '{8'h74, 0, 0, 0, 1, 10'h274, 24'h00001C};
    tbl[5]  = '{8'hE0, 0, 0, 0, 0, 10'h000, 24'h00001C};
    tbl[6]  = '{8'hF0, 0, 0, 0, 0, 10'h000, 24'h00001C};
    tbl[7]  = '{8'h74, 0, 0, 1, 1, 10'h374, 24'h001C74};
    tbl[8]  = '{8'hF0, 0, 0, 0, 0, 10'h000, 24'h001C74};
    tbl[9]  = '{8'h1C, 1, 1, 0, 0, 10'h000, 24'h001C74};
    tbl[10] = '{8'h1C, 0, 0, 0, 1, 10'h01C, 24'h001C74};

    // reset state
    repeat (3) @(negedge clk);
    check("rst_valid0", valid0, 0);
    check("rst_valid1", valid1, 0);
    check("rst_hist0", hist0, 0);
    check("rst_err_ovf", {err0, ovf0, err1, ovf1}, 0);
    reset = 1'b0;
    repeat (FILT_LEN + 2) @(negedge clk);

    // table: prefix decoding, REPORT_MAKE 0/1, parity error clears prefix
    for (int i = 0; i < 11; i++) begin
      e_base0 = err_seen[0];
      send_frame(tbl[i].code, tbl[i].bad);
      check("tbl_err", err_seen[0] - e_base0, tbl[i].n_err);
      check("tbl_valid0", valid0, tbl[i].ev0);
      check("tbl_valid1", valid1, tbl[i].ev1);
      if (tbl[i].ev0) check("tbl_head0", {ext0, brk0, code0}, tbl[i].ev);
      if (tbl[i].ev1) check("tbl_head1", {ext1, brk1, code1}, tbl[i].ev);
      check("tbl_hist", hist0, tbl[i].hist);
      pop_both();
    end

    // timeout: partial frame after F0 discards data and clears the prefix
    send_frame(8'hF0, 0);
    e_base0 = err_seen[0];
    e_base1 = err_seen[1];
    partial_timeout();
    check("to_err0", err_seen[0] - e_base0, 1);
    check("to_err1", err_seen[1] - e_base1, 1);
    send_frame(8'h2A, 0);
    check("to_prefix_cleared", valid0, 0);
    check("to_make1", {valid1, ext1, brk1, code1}, {1'b1, 10'h02A});
    pop_both();
    send_frame(8'hF0, 0);
    send_frame(8'h2A, 0);
    check("to_event0", {valid0, ext0, brk0, code0}, {1'b1, 10'h12A});
    check("to_hist", hist0, 24'h1C742A);
    pop_both();

    // overflow: five releases into a 4-deep FIFO with ready low
    o_base0 = ovf_seen[0];
    o_base1 = ovf_seen[1];
    begin
      logic [7:0] ov_codes[5];
      ov_codes = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C};
      for (int i = 0; i < 5; i++) begin
        send_frame(8'hF0, 0);
        send_frame(ov_codes[i], 0);
        if (i == 3) check("ovf_none_yet", ovf_seen[0] - o_base0, 0);
      end
    end
    check("ovf_once0", ovf_seen[0] - o_base0, 1);
    check("ovf_once1", ovf_seen[1] - o_base1, 1);
    check("ovf_hist", hist0, 24'h242D2C);
    exp_q0 = '{10'h115, 10'h11D, 10'h124, 10'h12D};
    exp_q1 = '{10'h115, 10'h11D, 10'h124, 10'h12D};
    drain(0);
    drain(1);

    // glitch mid-frame, then reset mid-frame
    send_frame(8'hF0, 0);
    send_bits(8'h33, 0, 11, 4);
    check("glitch_event", {valid0, ext0, brk0, code0}, {1'b1, 10'h133});
    send_bits(8'h5A, 0, 3, -1);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst_valid", {valid0, valid1}, 0);
    check("midrst_head", {ext0, brk0, code0}, 0);
    check("midrst_hist", {hist0, hist1}, 0);
    check("midrst_pulses", {err0, ovf0, err1, ovf1}, 0);
    reset = 1'b0;
    repeat (FILT_LEN + 2) @(negedge clk);
    send_frame(8'hF0, 0);
    send_frame(8'h4B, 0);
    check("postrst_event", {valid0, ext0, brk0, code0}, {1'b1, 10'h14B});
    check("postrst_hist", hist0, 24'h00004B);
    pop_both();

    // randomized stream against the byte-level model
    do_reset();
    model_reset();
    for (int n = 0; n < 50; n++) begin
      r = $urandom_range(0, 99);
      if (r < 5) begin
        partial_timeout();
        model_timeout();
      end else begin
        if (r < 20) rcode = 8'hE0;
        else if (r < 45) rcode = 8'hF0;
        else begin
          rcode = 8'($urandom_range(0, 255));
          if (rcode == 8'hE0 || rcode == 8'hF0) rcode = 8'h1C;
        end
        rbad = ($urandom_range(0, 99) < 8);
        send_frame(rcode, rbad);
        model_byte(rcode, rbad);
      end
      if ((n % 6) == 5 || n == 49) compare_model();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
